// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM state encoding and default sizing for the APB request arbiter.
package apb_arb_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_TIMEOUT  = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        COMPLETE,
        REJECT
    } arb_state_e;

endpackage

// File: rtl/apb_rr_arb.sv
// apb_rr_arb: two-input round-robin grant; a tie goes to the requester not granted last.
module apb_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_gnt,
    output logic       o_any
);

    logic r_last;

    always_comb begin
        o_any = |i_req;
        o_gnt = 1'b0;
        case (i_req)
            2'b10:   o_gnt = 1'b1;
            2'b11:   o_gnt = ~r_last;
            default: o_gnt = 1'b0;
        endcase
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_take) begin
            r_last <= o_gnt;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two requesters share one APB master port through a round-robin grant.
// Define APB_ARB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT cycles.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [ADDR_W:0] LP_ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    if (TIMEOUT < 1 || NUM_REGS < 1) begin : g_param_check
        $error("apb_req_arbiter: TIMEOUT and NUM_REGS must be positive");
    end

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic              w_gnt;
    logic              w_any;
    logic              w_take;
    logic              w_timeout;
    logic              w_finish;
    logic              w_bad_addr;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              r_gnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_psel;
    logic              r_penable;
    logic [1:0]        r_done;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_rdata [2];

    apb_rr_arb u_rr_arb (
        .i_clk   (pclk),
        .i_rst_n (presetn),
        .i_req   ({req1_valid, req0_valid}),
        .i_take  (w_take),
        .o_gnt   (w_gnt),
        .o_any   (w_any)
    );

    assign w_sel_write = w_gnt ? req1_write : req0_write;
    assign w_sel_addr  = w_gnt ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_gnt ? req1_wdata : req0_wdata;
    assign w_bad_addr  = ({1'b0, w_sel_addr} >= LP_ADDR_LIMIT);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    logic [TCNT_W-1:0] r_tcnt;

    // Counts consecutive ACCESS cycles; cleared whenever the phase is left or not yet entered.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_tcnt <= '0;
        end else if (r_state == ACCESS && w_next_state == ACCESS) begin
            r_tcnt <= r_tcnt + 1'b1;
        end else begin
            r_tcnt <= '0;
        end
    end

    assign w_timeout = (r_state == ACCESS) && !pready && (r_tcnt == TCNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_take       = 1'b1;
                    w_next_state = w_bad_addr ? REJECT : SETUP;
                end
            end
            SETUP:    w_next_state = ACCESS;
            ACCESS: begin
                if (pready || w_timeout) begin
                    w_next_state = COMPLETE;
                end
            end
            COMPLETE: w_next_state = IDLE;
            REJECT:   w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    assign w_finish = (r_state == ACCESS) && (w_next_state == COMPLETE);

    // All outputs are registered from the next state so no input reaches an output combinationally.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state    <= IDLE;
            r_gnt      <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_done     <= '0;
            r_err      <= '0;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
        end else begin
            r_state   <= w_next_state;
            r_psel    <= (w_next_state == SETUP) || (w_next_state == ACCESS);
            r_penable <= (w_next_state == ACCESS);
            r_done    <= '0;
            r_err     <= '0;
            if (w_take) begin
                r_gnt   <= w_gnt;
                r_write <= w_sel_write;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (w_take && w_bad_addr) begin
                r_done[w_gnt] <= 1'b1;
                r_err[w_gnt]  <= 1'b1;
            end
            if (w_finish) begin
                r_done[r_gnt] <= 1'b1;
                r_err[r_gnt]  <= w_timeout | pslverr;
                if (pready && !r_write) begin
                    r_rdata[r_gnt] <= prdata;
                end
            end
        end
    end

    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_write;
    assign paddr      = r_addr;
    assign pwdata     = r_wdata;
    assign req0_done  = r_done[0];
    assign req1_done  = r_done[1];
    assign req0_err   = r_err[0];
    assign req1_err   = r_err[1];
    assign req0_rdata = r_rdata[0];
    assign req1_rdata = r_rdata[1];

endmodule
